instruction_fetch_unit: RTL and testbench

Sequences instruction fetches for the 16-bit multicycle datapath: holds the program counter, issues read requests to instruction memory, and writes each returned word into the Instruction Register through its DataIn/RegWrite pins. It sits between the control unit, which starts fetches and redirects the PC, and the memory and Instruction Register. It is the writer side of the Instruction Register's load interface.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_pc_reg.sv | 55 +++++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default parameters for the instruction fetch unit
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LOAD = 2'd2
    } fetch_state_e;

    localparam int              ADDR_WIDTH_DEF     = 16;
    localparam int              DATA_WIDTH_DEF     = 16;
    localparam logic [15:0]     PC_RESET_DEF       = 16'h0000;
    localparam int              PC_STEP_DEF        = 2;
    localparam int              TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/fetch_pc_reg.sv
// rtl/fetch_pc_reg.sv - program counter with increment/wrap and a pending redirect latched while a fetch is in flight
module fetch_pc_reg #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET   = '0,
    parameter int                    PC_STEP    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  pc_write_i,
    input  logic [ADDR_WIDTH-1:0] pc_next_i,
    input  logic                  busy_i,
    input  logic                  advance_i,
    input  logic                  abort_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  pend_q, pend_d;

    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        if (!busy_i) begin
            if (pc_write_i) pc_d = pc_next_i;
        end else if (advance_i || abort_i) begin
            // A redirect arriving on the closing cycle is newer than anything pending
            if (pc_write_i)     pc_d = pc_next_i;
            else if (pend_q)    pc_d = pend_addr_q;
            else if (advance_i) pc_d = pc_q + STEP;
            pend_d = 1'b0;
        end else if (pc_write_i) begin
            pend_d      = 1'b1;
            pend_addr_d = pc_next_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q        <= PC_RESET;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch sequencer driving instruction memory and the Instruction Register load pins
// Optional REQ timeout selected by FETCH_TIMEOUT_EN.
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int                    DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter logic [ADDR_WIDTH-1:0] PC_RESET       = ADDR_WIDTH'(PC_RESET_DEF),
    parameter int                    PC_STEP        = PC_STEP_DEF,
    parameter int                    TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  FetchStart,
    input  logic                  PCWrite,
    input  logic [ADDR_WIDTH-1:0] PCNext,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    input  logic                  MemReady,
    input  logic [DATA_WIDTH-1:0] MemData,
    output logic [DATA_WIDTH-1:0] IRData,
    output logic                  IRWrite,
    output logic [ADDR_WIDTH-1:0] PC,
    output logic                  FetchBusy,
    output logic                  FetchDone,
    output logic                  FetchErr
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    fetch_state_e          state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q;
    logic                  timeout;
    logic [ADDR_WIDTH-1:0] pc;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q;

    assign cnt_d = (state_q == REQ) ? cnt_q + 1'b1 : '0;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= timeout;
        end
    end

    assign FetchErr = err_q;
`else
    assign FetchErr = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        timeout = 1'b0;
        case (state_q)
            IDLE: if (FetchStart) state_d = REQ;
            REQ: begin
                // MemReady on the final count cycle still completes the fetch
                if (MemReady) begin
                    state_d = LOAD;
`ifdef FETCH_TIMEOUT_EN
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
`endif
                end
            end
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == REQ && MemReady) ir_q <= MemData;
        end
    end

    fetch_pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PC_RESET   (PC_RESET),
        .PC_STEP    (PC_STEP)
    ) u_pc_reg (
        .clk_i      (CLK),
        .rst_i      (Reset),
        .pc_write_i (PCWrite),
        .pc_next_i  (PCNext),
        .busy_i     (state_q != IDLE),
        .advance_i  (state_q == LOAD),
        .abort_i    (timeout),
        .pc_o       (pc)
    );

    assign PC        = pc;
    assign MemAddr   = pc;
    assign MemRead   = (state_q == REQ);
    assign IRWrite   = (state_q == LOAD);
    assign FetchDone = (state_q == LOAD);
    assign FetchBusy = (state_q != IDLE);
    assign IRData    = ir_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - directed scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        FetchStart;
    logic        PCWrite;
    logic [15:0] PCNext;
    logic [15:0] MemAddr;
    logic        MemRead;
    logic        MemReady;
    logic [15:0] MemData;
    logic [15:0] IRData;
    logic        IRWrite;
    logic [15:0] PC;
    logic        FetchBusy;
    logic        FetchDone;
    logic        FetchErr;

    int total = 0;
    int bad   = 0;
    int ir_writes  = 0;
    int rd_cycles  = 0;
    int err_pulses = 0;
    logic [15:0] sb[$];

    always #5 CLK = ~CLK;

    instruction_fetch_unit dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .FetchStart (FetchStart),
        .PCWrite    (PCWrite),
        .PCNext     (PCNext),
        .MemAddr    (MemAddr),
        .MemRead    (MemRead),
        .MemReady   (MemReady),
        .MemData    (MemData),
        .IRData     (IRData),
        .IRWrite    (IRWrite),
        .PC         (PC),
        .FetchBusy  (FetchBusy),
        .FetchDone  (FetchDone),
        .FetchErr   (FetchErr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every IR write must match the oldest expected word
    always @(negedge CLK) begin
        if (MemRead) rd_cycles++;
        if (FetchErr) err_pulses++;
        if (IRWrite) begin
            ir_writes++;
            chk("done_with_irwrite", {31'd0, FetchDone}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_irwrite", {16'd0, IRData}, 32'hFFFF_FFFF);
            end else begin
                chk("irdata_sb", {16'd0, IRData}, {16'd0, sb.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic load_pc(input logic [15:0] addr);
        PCWrite = 1'b1;
        PCNext  = addr;
        step();
        PCWrite = 1'b0;
        chk("load_pc", {16'd0, PC}, {16'd0, addr});
    endtask

    task automatic do_fetch(input string tag, input logic [15:0] exp_addr, input logic [15:0] data,
                            input int waits, input logic start_pcw, input logic [15:0] start_next,
                            input logic redir, input logic [15:0] redir_addr, input logic [15:0] exp_pc);
        int rd0;
        int wr0;
        rd0 = rd_cycles;
        wr0 = ir_writes;
        FetchStart = 1'b1;
        PCWrite    = start_pcw;
        PCNext     = start_next;
        step();
        FetchStart = 1'b0;
        PCWrite    = 1'b0;
        chk({tag, "_busy"}, {31'd0, FetchBusy}, 32'd1);
        for (int i = 0; i < waits; i++) begin
            chk({tag, "_memread_wait"}, {31'd0, MemRead}, 32'd1);
            chk({tag, "_addr_wait"}, {16'd0, MemAddr}, {16'd0, exp_addr});
            if (redir && i == 0) begin
                PCWrite = 1'b1;
                PCNext  = redir_addr;
            end
            step();
            PCWrite = 1'b0;
        end
        chk({tag, "_memread"}, {31'd0, MemRead}, 32'd1);
        chk({tag, "_addr"}, {16'd0, MemAddr}, {16'd0, exp_addr});
        MemReady = 1'b1;
        MemData  = data;
        sb.push_back(data);
        step();
        MemReady = 1'b0;
        MemData  = 16'h0000;
        chk({tag, "_irwrite"}, {31'd0, IRWrite}, 32'd1);
        chk({tag, "_fetchdone"}, {31'd0, FetchDone}, 32'd1);
        chk({tag, "_memread_load"}, {31'd0, MemRead}, 32'd0);
        step();
        chk({tag, "_irwrite_off"}, {31'd0, IRWrite}, 32'd0);
        chk({tag, "_idle"}, {31'd0, FetchBusy}, 32'd0);
        chk({tag, "_pc"}, {16'd0, PC}, {16'd0, exp_pc});
        chk({tag, "_rd_cycles"}, rd_cycles - rd0, waits + 1);
        chk({tag, "_one_write"}, ir_writes - wr0, 32'd1);
    endtask

    initial begin
        int n;
        int wr0;
        Reset      = 1'b1;
        FetchStart = 1'b0;
        PCWrite    = 1'b0;
        PCNext     = 16'h0000;
        MemReady   = 1'b0;
        MemData    = 16'h0000;
        step();
        step();
        Reset = 1'b0;
        step();

        chk("rst_pc", {16'd0, PC}, 32'h0);
        chk("rst_memaddr", {16'd0, MemAddr}, 32'h0);
        chk("rst_irdata", {16'd0, IRData}, 32'h0);
        chk("rst_outs", {27'd0, MemRead, IRWrite, FetchBusy, FetchDone, FetchErr}, 32'h0);

        do_fetch("basic", 16'h0000, 16'h1234, 0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0002);
        do_fetch("waits", 16'h0002, 16'hBEEF, 4, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0004);
        chk("waits_irdata", {16'd0, IRData}, 32'hBEEF);

        load_pc(16'h0010);
        do_fetch("redir_busy", 16'h0010, 16'hA5A5, 2, 1'b0, 16'h0, 1'b1, 16'h0040, 16'h0040);
        do_fetch("redir_idle", 16'h0100, 16'h5A5A, 1, 1'b1, 16'h0100, 1'b0, 16'h0, 16'h0102);

        load_pc(16'hFFFE);
        do_fetch("wrap", 16'hFFFE, 16'hC3C3, 0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0000);

        wr0 = ir_writes;
        MemReady = 1'b1;
        MemData  = 16'hDEAD;
        step();
        MemReady = 1'b0;
        step();
        chk("ready_idle_ignored", {16'd0, IRData}, 32'hC3C3);
        chk("ready_idle_nowrite", ir_writes - wr0, 32'd0);

        wr0 = ir_writes;
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        n = 0;
`ifdef FETCH_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            if (!MemRead) break;
            n++;
            step();
        end
        chk("to_req_cycles", n, 32'd15);
        chk("to_err", {31'd0, FetchErr}, 32'd1);
        chk("to_idle", {31'd0, FetchBusy}, 32'd0);
        chk("to_pc", {16'd0, PC}, 32'h0);
        step();
        chk("to_err_pulse", {31'd0, FetchErr}, 32'd0);
        chk("to_err_count", err_pulses, 32'd1);
        chk("to_nowrite", ir_writes - wr0, 32'd0);
`else
        for (int i = 0; i < 20; i++) begin
            if (MemRead) n++;
            step();
        end
        chk("nto_memread_held", n, 32'd20);
        chk("nto_no_err", err_pulses, 32'd0);
        chk("nto_nowrite", ir_writes - wr0, 32'd0);
        MemReady = 1'b1;
        MemData  = 16'h7E7E;
        sb.push_back(16'h7E7E);
        step();
        MemReady = 1'b0;
        step();
        chk("nto_pc", {16'd0, PC}, 32'h0002);
`endif

        load_pc(16'h0200);
        wr0 = ir_writes;
        FetchStart = 1'b1;
        step();
        FetchStart = 1'b0;
        chk("rmf_in_req", {31'd0, MemRead}, 32'd1);
        #2;
        Reset    = 1'b1;
        MemReady = 1'b1;
        MemData  = 16'hFFFF;
        #1;
        chk("rmf_memread", {31'd0, MemRead}, 32'd0);
        chk("rmf_busy", {31'd0, FetchBusy}, 32'd0);
        chk("rmf_irwrite", {31'd0, IRWrite}, 32'd0);
        chk("rmf_pc", {16'd0, PC}, 32'h0);
        step();
        Reset    = 1'b0;
        MemReady = 1'b0;
        step();
        chk("rmf_idle", {31'd0, FetchBusy}, 32'd0);
        chk("rmf_irdata", {16'd0, IRData}, 32'h0);
        chk("rmf_nowrite", ir_writes - wr0, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
